// File: rtl/selftest_sequencer_if.sv
// Handshake bundle between the self-test sequencer and the designs it exercises.
// The sequencer drives a one-hot enable; each design answers with a done strobe
// and a pass flag that is only meaningful while its done bit is high.
interface selftest_sequencer_if #(
    parameter int N_DESIGNS = 5
);
    logic [N_DESIGNS-1:0] o_enable;
    logic [N_DESIGNS-1:0] i_done;
    logic [N_DESIGNS-1:0] i_pass;

    modport master (
        output o_enable,
        input  i_done,
        input  i_pass
    );

    modport slave (
        input  o_enable,
        output i_done,
        output i_pass
    );
endinterface

// File: rtl/selftest_sequencer.sv
// Self-test sequencer: on a rising edge of the pad test request it enables each
// sub-design in turn, records its pass bit (or a timeout), and keeps a sticky
// fail flag. Dropping the request mid-sequence aborts back to idle.
module selftest_sequencer #(
    parameter int N_DESIGNS = 5,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_test,
    selftest_sequencer_if.master io_bus,
    output logic [N_DESIGNS-1:0] o_result,
    output logic                 o_busy,
    output logic                 o_fail
);

    localparam int               IDX_W    = (N_DESIGNS > 1) ? $clog2(N_DESIGNS) : 1;
    localparam logic [15:0]      CNT_LAST = 16'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DESIGNS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [15:0]            r_cnt;
    logic [N_DESIGNS-1:0]   r_enable;
    logic [N_DESIGNS-1:0]   r_result;
    logic                   r_busy;
    logic                   r_fail;

    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_sync2_d;

    logic                   w_rise;
    logic [IDX_W-1:0]       w_idx_inc;
    logic [N_DESIGNS-1:0]   w_onehot_next;
    logic                   w_done_cur;
    logic                   w_pass_cur;

    // Only the strobe of the currently enabled design matters; the rest are ignored.
    assign w_rise        = r_sync2 & ~r_sync2_d;
    assign w_idx_inc     = r_idx + IDX_W'(1);
    assign w_onehot_next = N_DESIGNS'(1) << w_idx_inc;
    assign w_done_cur    = io_bus.i_done[r_idx];
    assign w_pass_cur    = io_bus.i_pass[r_idx];

    assign io_bus.o_enable = r_enable;
    assign o_result        = r_result;
    assign o_busy          = r_busy;
    assign o_fail          = r_fail;

    // Bring the asynchronous pad request into the clock domain and keep a delayed copy for edge detection.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync2_d <= 1'b0;
        end else begin
            r_sync1   <= i_test;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
        end
    end

    // Sequencing FSM: walk through the designs, record results, handle timeout and abort.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_enable <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_fail   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_rise) begin
                        r_result <= '0;
                        r_fail   <= 1'b0;
                        r_idx    <= '0;
                        r_cnt    <= '0;
                        r_enable <= N_DESIGNS'(1);
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (!r_sync2) begin
                        r_enable <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (w_done_cur) begin
                        r_result[r_idx] <= w_pass_cur;
                        if (!w_pass_cur) begin
                            r_fail <= 1'b1;
                        end
                        r_enable <= '0;
                        r_state  <= S_NEXT;
                    end else if (r_cnt == CNT_LAST) begin
                        r_result[r_idx] <= 1'b0;
                        r_fail          <= 1'b1;
                        r_enable        <= '0;
                        r_state         <= S_NEXT;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_NEXT: begin
                    if (!r_sync2) begin
                        r_enable <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (r_idx == IDX_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx    <= w_idx_inc;
                        r_cnt    <= '0;
                        r_enable <= w_onehot_next;
                        r_state  <= S_RUN;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/selftest_sequencer.md
SELFTEST_SEQUENCER -- requirements
Module: selftest_sequencer

Interface
REQ-001 Parameter N_DESIGNS, default 5: number of sub-designs sequenced; also the width of o_result, o_enable, i_done and i_pass.
REQ-002 Parameter TIMEOUT, default 1024: maximum RUN cycles allowed per design; legal range is 2 to 65535.
REQ-003 Port i_clock, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port i_reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port i_test, input, 1: test request from the pad; asynchronous to i_clock.
REQ-006 Port o_enable, output, N_DESIGNS: one-hot enable to the design under test.
REQ-007 Port i_done, input, N_DESIGNS: per-design completion strobe.
REQ-008 Port i_pass, input, N_DESIGNS: per-design pass flag, valid only when the matching i_done bit is high.
REQ-009 Port o_result, output, N_DESIGNS: per-design pass bits, driven to the pads.
REQ-010 Port o_busy, output, 1: high while a sequence is running.
REQ-011 Port o_fail, output, 1: sticky flag, set by any fail or timeout within a sequence.

Function
REQ-012 i_test SHALL pass through a 2-flop synchronizer; a rising edge is detected by comparing the second sync stage with its registered copy.
REQ-013 FSM states SHALL be IDLE, RUN, NEXT and DONE, with state and all outputs registered.
REQ-014 IDLE/DONE on a detected rising edge: clear o_result and o_fail, set idx=0, clear the timeout counter, go to RUN.
- o_enable[0] and o_busy SHALL be high after the 3rd rising i_clock edge on which i_test is sampled high.
REQ-015 RUN: o_enable = 1<<idx; the counter increments every cycle.
- i_done[idx] high: o_result[idx] <= i_pass[idx]; if i_pass[idx]=0, set o_fail; go to NEXT.
REQ-016 RUN timeout: when the counter reaches TIMEOUT-1 with no i_done[idx], o_result[idx] <= 0, o_fail <= 1, go to NEXT.
- If done and timeout occur in the same cycle, done SHALL win.
REQ-017 In RUN, i_done and i_pass bits other than idx SHALL be ignored.
REQ-018 NEXT: o_enable SHALL be all-zero for exactly one cycle.
- idx = N_DESIGNS-1: go to DONE.
- Otherwise idx++, clear the counter, go to RUN.
REQ-019 DONE: o_busy=0, o_enable=0; o_result and o_fail SHALL be held until the next detected rising edge.
REQ-020 Abort: synchronized i_test low while in RUN or NEXT → IDLE next cycle, with o_enable=0 and o_busy=0.
- o_result SHALL keep the bits already written; unwritten bits SHALL stay 0; o_fail SHALL be unchanged.
REQ-021 A rising edge while in RUN or NEXT SHALL be impossible by REQ-020 and need not be handled specially.
REQ-022 Counter width SHALL be 16 bits; it SHALL NOT wrap, because the timeout check precedes overflow.

Reset
REQ-023 While i_reset_n=0, asynchronously force: state=IDLE, idx=0, counter=0, synchronizer flops=0, o_enable=0, o_result=0, o_busy=0, o_fail=0.
REQ-024 Reset asserted mid-sequence SHALL abort immediately.
- After release, no sequence SHALL start until a fresh low-to-high i_test is seen by the synchronizer.
- i_test held high through reset release SHALL count as a rising edge once it is synchronized.

Verification
REQ-025 All pass: i_test rises; each design asserts i_done=1, i_pass=1 ten cycles after its enable.
- o_enable walks 00001 → 10000 with one idle cycle between designs.
- o_result ends at 11111, o_fail=0, o_busy=0.
REQ-026 Single fail: design 2 returns i_pass=0.
- o_result=11011, o_fail=1.
REQ-027 Timeout: design 3 never asserts i_done, TIMEOUT=16.
- o_enable[3] high for exactly 16 cycles; final o_result=10111, o_fail=1.
REQ-028 Simultaneous and stray strobes: design 1 asserts i_done on exactly cycle TIMEOUT-1 with i_pass=1, while i_done[4] pulses during design 0.
- o_result[1]=1; the pulse on i_done[4] SHALL have no effect.
REQ-029 Abort: i_test drops during design 2 (after 0 and 1 pass).
- IDLE within 3 cycles; o_result=00011; o_enable=0.
- A new i_test rise restarts the sequence with o_result cleared.
REQ-030 Reset mid-run: i_reset_n=0 during design 3.
- All outputs 0 in the same timestep.
- i_test held high through release: o_enable[0] asserts 3 edges after release.
